// File: rtl/conv_weight_loader.sv
// Kernel-weight loader: packs KSIZE*KSIZE signed weights from a word stream into
// one wide kernel bus, with an assembly slot and an output slot for overlap.
module conv_weight_loader #(
    parameter int DATA_W      = 32,
    parameter int WEIGHT_W    = 8,
    parameter int KSIZE       = 3,
    parameter int MAX_KERNELS = 4,
    localparam int WPK   = KSIZE * KSIZE,
    localparam int BPW   = DATA_W / WEIGHT_W,
    localparam int WPKW  = (WPK + BPW - 1) / BPW,
    localparam int IDX_W = (MAX_KERNELS > 1) ? $clog2(MAX_KERNELS) : 1,
    localparam int CNT_W = $clog2(MAX_KERNELS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_num_k,
    input  logic                    i_w_valid,
    input  logic [DATA_W-1:0]       i_w_data,
    output logic                    o_w_ready,
    output logic                    o_k_valid,
    input  logic                    i_k_ready,
    output logic [WPK*WEIGHT_W-1:0] o_weights,
    output logic [IDX_W-1:0]        o_k_idx,
    output logic                    o_done,
    output logic [1:0]              o_dbg_state
);

    localparam int WC_W = (WPKW > 1) ? $clog2(WPKW) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPKW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [WC_W-1:0]         word_cnt;
    logic [IDX_W-1:0]        asm_idx;
    logic [CNT_W-1:0]        num_k_q;
    logic [WPK*WEIGHT_W-1:0] asm_buf;
    logic [WPK*WEIGHT_W-1:0] asm_next;
    logic [CNT_W-1:0]        num_k_eff;
    logic                    accept;
    logic                    last_word;
    logic                    out_free;
    logic                    last_kernel;
    logic                    transfer;
    logic                    done_d;

    // Both ports use the same rule: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits on ready, and a raised
    // o_k_valid keeps o_weights/o_k_idx stable until it is accepted.
    assign o_w_ready   = (state == S_LOAD);
    assign o_dbg_state = state;

    assign num_k_eff   = (i_num_k > CNT_W'(MAX_KERNELS)) ? CNT_W'(MAX_KERNELS) : i_num_k;
    assign accept      = o_w_ready && i_w_valid;
    assign last_word   = (word_cnt == LAST_WORD);
    assign out_free    = !o_k_valid || i_k_ready;
    assign last_kernel = ((CNT_W'(asm_idx) + CNT_W'(1)) == num_k_q);

    // Merge the incoming word into the assembly image; byte 0 sits at the MSBs.
    always_comb begin
        int widx;
        widx     = 0;
        asm_next = asm_buf;
        if (accept) begin
            for (int j = 0; j < BPW; j++) begin
                widx = int'(word_cnt) * BPW + j;
                if (widx < WPK) begin
                    asm_next[(WPK-1-widx)*WEIGHT_W +: WEIGHT_W] =
                        i_w_data[(BPW-1-j)*WEIGHT_W +: WEIGHT_W];
                end
            end
        end
    end

    always_comb begin
        state_d  = state;
        transfer = 1'b0;
        done_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) state_d = (num_k_eff == '0) ? S_FLUSH : S_LOAD;
            end
            S_LOAD: begin
                if (accept && last_word) begin
                    if (out_free) begin
                        transfer = 1'b1;
                        state_d  = last_kernel ? S_FLUSH : S_LOAD;
                    end else begin
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    transfer = 1'b1;
                    state_d  = last_kernel ? S_FLUSH : S_LOAD;
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            o_done <= 1'b0;
        end else begin
            state  <= state_d;
            o_done <= done_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt <= '0;
            asm_idx  <= '0;
            num_k_q  <= '0;
            asm_buf  <= '0;
        end else begin
            if (state == S_IDLE && i_start && num_k_eff != '0) begin
                num_k_q  <= num_k_eff;
                word_cnt <= '0;
                asm_idx  <= '0;
            end
            if (accept) begin
                asm_buf  <= asm_next;
                word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
            end
            if (transfer) asm_idx <= asm_idx + IDX_W'(1);
        end
    end

    // Output slot: loads on transfer, empties on handshake otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_k_valid <= 1'b0;
            o_weights <= '0;
            o_k_idx   <= '0;
        end else if (transfer) begin
            o_k_valid <= 1'b1;
            o_weights <= asm_next;
            o_k_idx   <= asm_idx;
        end else if (i_k_ready) begin
            o_k_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: random words checked against a byte-queue
// packing model, plus timing, backpressure, control-corner and reset scenarios.
module tb_conv_weight_loader;

    localparam int DATA_W      = 32;
    localparam int WEIGHT_W    = 8;
    localparam int KSIZE       = 3;
    localparam int MAX_KERNELS = 4;
    localparam int WPK         = KSIZE * KSIZE;
    localparam int BPW         = DATA_W / WEIGHT_W;
    localparam int WPKW        = (WPK + BPW - 1) / BPW;
    localparam int IDX_W       = (MAX_KERNELS > 1) ? $clog2(MAX_KERNELS) : 1;
    localparam int CNT_W       = $clog2(MAX_KERNELS + 1);
    localparam int KW          = WPK * WEIGHT_W;

    logic              clk;
    logic              i_rst_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_num_k;
    logic              i_w_valid;
    logic [DATA_W-1:0] i_w_data;
    logic              o_w_ready;
    logic              o_k_valid;
    logic              i_k_ready;
    logic [KW-1:0]     o_weights;
    logic [IDX_W-1:0]  o_k_idx;
    logic              o_done;
    logic [1:0]        o_dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] in_q[$];
    logic [KW-1:0]     exp_q[$];
    logic [IDX_W-1:0]  exp_idx_q[$];
    int                hs_cyc_q[$];

    logic              prev_stall = 1'b0;
    logic [KW-1:0]     prev_w;
    logic [IDX_W-1:0]  prev_idx;

    conv_weight_loader #(
        .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .KSIZE(KSIZE), .MAX_KERNELS(MAX_KERNELS)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_k(i_num_k),
        .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(o_w_ready),
        .o_k_valid(o_k_valid), .i_k_ready(i_k_ready), .o_weights(o_weights),
        .o_k_idx(o_k_idx), .o_done(o_done), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic next_slot;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [KW-1:0] model_kernel(input logic [DATA_W-1:0] kw [WPKW]);
        logic [WEIGHT_W-1:0] bytes_q[$];
        logic [KW-1:0] k;
        k = '0;
        for (int w = 0; w < WPKW; w++)
            for (int j = 0; j < BPW; j++)
                bytes_q.push_back(kw[w][DATA_W-1-j*WEIGHT_W -: WEIGHT_W]);
        for (int i = 0; i < WPK; i++)
            k = (k << WEIGHT_W) | KW'(bytes_q[i]);
        return k;
    endfunction

    task automatic plan_kernel(input logic [DATA_W-1:0] kw [WPKW], input int idx);
        for (int w = 0; w < WPKW; w++) in_q.push_back(kw[w]);
        exp_q.push_back(model_kernel(kw));
        exp_idx_q.push_back(IDX_W'(idx));
    endtask

    task automatic plan_random(input int nk);
        logic [DATA_W-1:0] kw [WPKW];
        for (int k = 0; k < nk; k++) begin
            for (int w = 0; w < WPKW; w++) kw[w] = $urandom;
            plan_kernel(kw, k);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (o_k_valid !== 1'b1 || o_weights !== prev_w || o_k_idx !== prev_idx) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b w=%h idx=%0d required valid=1 w=%h idx=%0d",
                             o_k_valid, o_weights, o_k_idx, prev_w, prev_idx);
                end
            end
            if (o_k_valid && i_k_ready) begin
                hs_cyc_q.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_kernel: w=%h idx=%0d required none", o_weights, o_k_idx);
                end else begin
                    logic [KW-1:0]    ew;
                    logic [IDX_W-1:0] ei;
                    ew = exp_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (o_weights !== ew || o_k_idx !== ei) begin
                        bad++;
                        $display("FAIL kernel: w=%h idx=%0d required w=%h idx=%0d",
                                 o_weights, o_k_idx, ew, ei);
                    end
                end
            end
            if (o_done) done_cnt++;
            prev_stall = o_k_valid && !i_k_ready;
            prev_w     = o_weights;
            prev_idx   = o_k_idx;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input int n);
        i_start = 1'b1;
        i_num_k = CNT_W'(n);
        next_slot;
        i_start = 1'b0;
        i_num_k = CNT_W'($urandom);
    endtask

    task automatic drive_words(input int nwords, input int gap_pct, output int cycles);
        cycles = 0;
        for (int i = 0; i < nwords; i++) begin
            logic [DATA_W-1:0] w;
            bit acc;
            int guard;
            w = in_q.pop_front();
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                bit v;
                v = ($urandom_range(99) >= gap_pct);
                i_w_valid = v;
                i_w_data  = v ? w : DATA_W'($urandom);
                acc = v && o_w_ready;
                next_slot;
                cycles++;
                guard++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL word_timeout: word %0d not accepted, ready=%b required 1", i, o_w_ready);
            end
        end
        i_w_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 100) begin
            next_slot;
            n++;
        end
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: o_done=%b required 1 within 100 cycles", name, o_done);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d kernels left required 0", name, exp_q.size());
        end
        next_slot;
        total++;
        if (o_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_pulse: o_done=%b required 0", name, o_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (3) next_slot;
        total++;
        if (o_w_ready !== 1'b0 || o_k_valid !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b kvalid=%b done=%b required 0 0 0", o_w_ready, o_k_valid, o_done);
        end
        total++;
        if (o_weights !== '0 || o_k_idx !== '0) begin
            bad++;
            $display("FAIL reset_data: w=%h idx=%0d required 0 0", o_weights, o_k_idx);
        end
        total++;
        if (o_dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d required 0 (idle)", o_dbg_state);
        end
        i_rst_n = 1'b1;
        next_slot;
        total++;
        if (o_w_ready !== 1'b0 || o_k_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: ready=%b kvalid=%b required 0 0", o_w_ready, o_k_valid);
        end
    endtask

    task automatic test_single;
        logic [DATA_W-1:0] kw [WPKW];
        int c;
        kw[0] = 32'h01020304;
        kw[1] = 32'h05060708;
        kw[2] = 32'h09AABBCC;
        plan_kernel(kw, 0);
        i_k_ready = 1'b1;
        start_run(1);
        total++;
        if (o_w_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: o_w_ready=%b required 1 after start", o_w_ready);
        end
        drive_words(WPKW, 0, c);
        total++;
        if (o_k_valid !== 1'b1 || o_weights !== 72'h010203040506070809 || o_k_idx !== '0) begin
            bad++;
            $display("FAIL single_kernel: valid=%b w=%h idx=%0d required 1 010203040506070809 0",
                     o_k_valid, o_weights, o_k_idx);
        end
        next_slot;
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL single_done: o_done=%b required 1 one cycle after handshake", o_done);
        end
        next_slot;
        total++;
        if (o_done !== 1'b0 || o_k_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_end: done=%b kvalid=%b pending=%0d required 0 0 0",
                     o_done, o_k_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int c;
        int base;
        base = hs_cyc_q.size();
        i_k_ready = 1'b1;
        plan_random(4);
        start_run(4);
        drive_words(4 * WPKW, 0, c);
        total++;
        if (c != 4 * WPKW) begin
            bad++;
            $display("FAIL stream_cycles: %0d cycles required %0d", c, 4 * WPKW);
        end
        wait_done("stream");
        total++;
        if (hs_cyc_q.size() - base != 4) begin
            bad++;
            $display("FAIL stream_count: %0d kernels required 4", hs_cyc_q.size() - base);
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (hs_cyc_q[base+i] - hs_cyc_q[base+i-1] != WPKW) begin
                    bad++;
                    $display("FAIL stream_spacing: gap %0d required %0d",
                             hs_cyc_q[base+i] - hs_cyc_q[base+i-1], WPKW);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int c;
        i_k_ready = 1'b0;
        plan_random(2);
        start_run(2);
        drive_words(2 * WPKW, 0, c);
        total++;
        if (o_w_ready !== 1'b0 || o_dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL bp_hold: ready=%b state=%0d required 0 2 (hold)", o_w_ready, o_dbg_state);
        end
        total++;
        if (o_k_valid !== 1'b1 || o_k_idx !== IDX_W'(0)) begin
            bad++;
            $display("FAIL bp_k0: valid=%b idx=%0d required 1 0", o_k_valid, o_k_idx);
        end
        for (int i = 0; i < 4; i++) begin
            i_w_valid = 1'b1;
            i_w_data  = $urandom;
            next_slot;
            total++;
            if (o_w_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready_low: o_w_ready=%b required 0", o_w_ready);
            end
        end
        i_k_ready = 1'b1;
        next_slot;
        total++;
        if (o_k_valid !== 1'b1 || o_k_idx !== IDX_W'(1)) begin
            bad++;
            $display("FAIL bp_k1_transfer: valid=%b idx=%0d required 1 1", o_k_valid, o_k_idx);
        end
        wait_done("bp");
        i_w_valid = 1'b0;
    endtask

    task automatic test_bursty;
        int c;
        bit words_done;
        words_done = 1'b0;
        plan_random(3);
        start_run(3);
        fork
            begin
                drive_words(3 * WPKW, 40, c);
                words_done = 1'b1;
            end
            begin
                while (!words_done) begin
                    i_k_ready = $urandom_range(1);
                    next_slot;
                end
            end
        join
        i_k_ready = 1'b1;
        wait_done("bursty");
    endtask

    task automatic test_control;
        int c;
        int base_done;
        int base_hs;
        i_k_ready = 1'b1;
        // start while loading must not restart or resize the run
        plan_random(1);
        start_run(1);
        drive_words(1, 0, c);
        i_start = 1'b1;
        i_num_k = CNT_W'(3);
        next_slot;
        i_start = 1'b0;
        total++;
        if (o_w_ready !== 1'b1) begin
            bad++;
            $display("FAIL ctl_start_in_load: o_w_ready=%b required 1", o_w_ready);
        end
        drive_words(WPKW - 1, 0, c);
        wait_done("ctl_ignore_start");
        repeat (3) next_slot;
        total++;
        if (o_k_valid !== 1'b0 || o_w_ready !== 1'b0) begin
            bad++;
            $display("FAIL ctl_no_extra: kvalid=%b ready=%b required 0 0", o_k_valid, o_w_ready);
        end
        // zero kernels: only a done pulse
        base_done = done_cnt;
        base_hs   = hs_cyc_q.size();
        start_run(0);
        wait_done("ctl_zero");
        total++;
        if (done_cnt - base_done != 1 || hs_cyc_q.size() != base_hs) begin
            bad++;
            $display("FAIL ctl_zero: dones=%0d kernels=%0d required 1 0",
                     done_cnt - base_done, hs_cyc_q.size() - base_hs);
        end
        // oversize request clamps to MAX_KERNELS
        base_hs = hs_cyc_q.size();
        plan_random(MAX_KERNELS);
        start_run(7);
        drive_words(MAX_KERNELS * WPKW, 0, c);
        wait_done("ctl_clamp");
        total++;
        if (hs_cyc_q.size() - base_hs != MAX_KERNELS || o_w_ready !== 1'b0) begin
            bad++;
            $display("FAIL ctl_clamp: kernels=%0d ready=%b required %0d 0",
                     hs_cyc_q.size() - base_hs, o_w_ready, MAX_KERNELS);
        end
    endtask

    task automatic test_reset_midrun;
        int c;
        int base_done;
        base_done = done_cnt;
        i_k_ready = 1'b0;
        plan_random(2);
        start_run(2);
        drive_words(5, 0, c);
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_k_valid !== 1'b0 || o_w_ready !== 1'b0 || o_done !== 1'b0 ||
            o_weights !== '0 || o_k_idx !== '0 || o_dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid: kvalid=%b ready=%b done=%b w=%h idx=%0d state=%0d required all 0",
                     o_k_valid, o_w_ready, o_done, o_weights, o_k_idx, o_dbg_state);
        end
        exp_q.delete();
        exp_idx_q.delete();
        in_q.delete();
        repeat (2) next_slot;
        i_rst_n = 1'b1;
        i_k_ready = 1'b1;
        repeat (3) next_slot;
        total++;
        if (done_cnt != base_done) begin
            bad++;
            $display("FAIL rst_no_done: dones=%0d required 0", done_cnt - base_done);
        end
        plan_random(2);
        start_run(2);
        drive_words(2 * WPKW, 20, c);
        wait_done("rst_rerun");
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_num_k   = '0;
        i_w_valid = 1'b0;
        i_w_data  = '0;
        i_k_ready = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        for (int r = 0; r < 4; r++) test_bursty;
        test_control;
        test_reset_midrun;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_weight_loader.md
# conv_weight_loader

Parametrised kernel-weight loader for the CONV stage. It collects a run of KSIZE×KSIZE signed weights per kernel from the shared 32-bit input stream, packs each kernel into one wide bus and hands kernels to the engine through a valid/ready port. A two-slot buffer (assembly + output) lets the next kernel load while the engine still holds the previous one. A one-cycle done pulse follows the last accepted kernel.

## Interface
- DATA_W, 32: input word width; must be a multiple of WEIGHT_W.
- WEIGHT_W, 8: bits per weight (two's complement, passed through unchanged).
- KSIZE, 3: kernel side; weights per kernel WPK = KSIZE*KSIZE.
- MAX_KERNELS, 4: maximum kernels per run.
- Derived: BPW = DATA_W/WEIGHT_W; WPKW = ceil(WPK/BPW) words per kernel; IDX_W = max(1, clog2(MAX_KERNELS)); CNT_W = clog2(MAX_KERNELS+1).

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_num_k  in  CNT_W  kernels in this run; sampled with i_start; values above MAX_KERNELS are clamped to MAX_KERNELS.
- i_w_valid  in  1  input word valid.
- i_w_data  in  DATA_W  input word.
- o_w_ready  out  1  input word accepted when i_w_valid && o_w_ready.
- o_k_valid  out  1  output kernel valid.
- i_k_ready  in  1  engine accepts the kernel when o_k_valid && i_k_ready.
- o_weights  out  WPK*WEIGHT_W  {w0,…,w(WPK-1)}; w0 in the MSBs.
- o_k_idx  out  IDX_W  kernel index 0..num_k-1 of o_weights.
- o_done  out  1  one-cycle pulse ending the run.

## Operation
- States:
  - IDLE: o_w_ready=0.
  - LOAD: assembly slot is filling; o_w_ready=1.
  - HOLD: assembly slot is full and the output slot is occupied; o_w_ready=0.
  - FLUSH: all kernels have been assembled; waiting for the output slot to drain.
- o_w_ready is decoded from registered state only; it has no combinational path from any input.
- IDLE + i_start:
  - num_k==0: go to FLUSH. The output slot is empty, so o_done pulses the next cycle.
  - otherwise: latch num_k, clear word_cnt and kernel counters, go to LOAD.
- Packing per accepted word:
  - Byte j of the word (j=0 at the MSBs) becomes weight word_cnt*BPW + j.
  - Bytes with index ≥ WPK in the final word are discarded.
  - Each kernel starts on a fresh word.
- End-of-kernel: the last word (word_cnt==WPKW-1) is accepted.
  - The assembly slot moves to the output slot if the output slot is empty, or is being freed this cycle (o_k_valid && i_k_ready).
  - Otherwise go to HOLD and keep the assembly contents.
  - On transfer: o_k_idx = assembly kernel index; the assembly index increments.
- After the transfer of the last kernel (index num_k-1), go to FLUSH. Otherwise stay in or return to LOAD.
- HOLD: when the output handshake completes, transfer in that same cycle and go to LOAD or FLUSH per the rule above.
- FLUSH: o_done is registered high in the cycle after the output slot becomes empty. The state returns to IDLE together with o_done.
- Output slot stability: while o_k_valid && !i_k_ready, o_weights and o_k_idx hold stable.
- Ignored inputs:
  - i_w_valid outside LOAD.
  - i_start outside IDLE.

## Timing
- Reset: state=IDLE; o_w_ready, o_k_valid, o_done = 0; o_weights = 0; o_k_idx = 0; all counters 0.
- Reset mid-run discards all partial and held kernels. No o_done is produced.
- Input side: the first word can be accepted the cycle after i_start (LOAD entered on that edge).
- Latency: last word accepted in cycle t → o_k_valid=1 in t+1.
- Throughput: with i_w_valid and i_k_ready held at 1, words are accepted every cycle with no bubbles. Kernels appear every WPKW cycles.
- Simultaneous events:
  - Output drain and assembly completion in the same cycle: transfer, no stall.
  - Word arriving while in HOLD: not accepted.
- o_done is asserted one cycle after the handshake of kernel num_k-1. The earliest next i_start is accepted in the cycle o_done is high.

## Test plan
- **Single kernel** (defaults, i_num_k=1): words 0x01020304, 0x05060708, 0x09AABBCC → o_weights=0x010203040506070809, o_k_idx=0, o_k_valid in the cycle after word 3. o_done pulses one cycle after the kernel handshake.
- **Streaming** (i_num_k=4, valid/ready held at 1): 12 words accepted in 12 consecutive cycles. Kernels idx 0..3, one every 3 cycles, with no ready gap.
- **Backpressure** (i_k_ready=0 for 10 cycles, i_num_k=2): kernel 0 holds stable. Kernel 1 assembles, state goes to HOLD, o_w_ready=0. After ready returns, kernel 1 is transferred in the same cycle.
- **Bursty input**: random i_w_valid gaps → packing identical to the gap-free case. Reserved bytes of the final word (0xAABBCC) never appear on o_weights.
- **Control corners**:
  - i_start during LOAD is ignored.
  - i_num_k=0 → o_done is the only output.
  - i_num_k=7 with MAX_KERNELS=4 → exactly 4 kernels.
- **Reset mid-run**: assert i_rst_n=0 after 5 words → outputs return to their reset values immediately. A new run afterwards produces correct kernels.
